pattern_detector_moore: RTL and testbench

- Parametrised successor to the fixed-pattern Moore serial sequence detector.
- Detects a runtime-loadable bit pattern of length 1..MAX_LEN on a 1-bit serial input qualified by a valid strobe.
- Supports overlapping and non-overlapping detection and counts matches in a saturating counter.
- Sits behind a serial front end and feeds event/interrupt logic. The output is registered and is a pure function of state (Moore).

---
 rtl/pattern_det_pkg.sv | 17 +
 rtl/sat_counter.sv | 27 ++
 rtl/pattern_detector_moore.sv | 86 ++++++++
 tb/tb_pattern_detector_moore.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_det_pkg.sv
// rtl/pattern_det_pkg.sv - shared types and helpers for the serial pattern detector
package pattern_det_pkg;

  typedef enum logic {MODE_NON_OVERLAP = 1'b0, MODE_OVERLAP = 1'b1} det_mode_t;

  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // A zero-length pattern is meaningless, so it is treated as a single bit.
  function automatic int clamp_len(input int len, input int max_len);
    if (len < 1) return 1;
    if (len > max_len) return max_len;
    return len;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating counter, clear applied before increment
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = clr ? '0 : cnt_q;
    if (inc && (cnt_d != '1)) cnt_d = cnt_d + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pattern_detector_moore.sv
// rtl/pattern_detector_moore.sv - runtime-loadable serial pattern detector, Moore output
module pattern_detector_moore
  import pattern_det_pkg::*;
#(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 16,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'b0000_1011),
  parameter int                 DEF_LEN     = 4,
  parameter bit                 DEF_OVERLAP = 1'b1,
  localparam int                LEN_W       = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               in,
  input  logic               pat_load,
  input  logic [MAX_LEN-1:0] pat_value,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               pat_overlap,
  input  logic               clr_count,
  output logic               out,
  output logic [CNT_W-1:0]   match_count
);

  // The oldest bit drops out of the window on every shift, so only MAX_LEN-1 bits need storing.
  logic [MAX_LEN-2:0] hist_q;
  logic [MAX_LEN-1:0] hist_d;
  logic [MAX_LEN-1:0] pat_q;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill_q;
  logic [LEN_W-1:0]   fill_d;
  logic [LEN_W-1:0]   len_q;
  det_mode_t          ovl_q;
  logic               out_q;
  logic               match_d;
  logic               accept;

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) mask[i] = (LEN_W'(i) < len_q);

    hist_d = {hist_q, in};

    // Non-overlap: the bit after a match starts a fresh window.
    if ((ovl_q == MODE_NON_OVERLAP) && out_q) fill_d = LEN_W'(1);
    else if (fill_q >= LEN_W'(MAX_LEN))       fill_d = LEN_W'(MAX_LEN);
    else                                      fill_d = fill_q + LEN_W'(1);

    match_d = (fill_d >= len_q) && ((hist_d & mask) == (pat_q & mask));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
      out_q  <= 1'b0;
      pat_q  <= DEF_PATTERN;
      len_q  <= LEN_W'(clamp_len(DEF_LEN, MAX_LEN));
      ovl_q  <= DEF_OVERLAP ? MODE_OVERLAP : MODE_NON_OVERLAP;
    end else if (pat_load) begin
      hist_q <= '0;
      fill_q <= '0;
      out_q  <= 1'b0;
      pat_q  <= pat_value;
      len_q  <= LEN_W'(clamp_len(int'(pat_len), MAX_LEN));
      ovl_q  <= pat_overlap ? MODE_OVERLAP : MODE_NON_OVERLAP;
    end else if (en) begin
      hist_q <= hist_d[MAX_LEN-2:0];
      fill_q <= fill_d;
      out_q  <= match_d;
    end
  end

  assign accept = en & ~pat_load;

  sat_counter #(.W(CNT_W)) u_match_cnt (
    .clk (clk),
    .rst (reset),
    .clr (clr_count | pat_load),
    .inc (accept & match_d),
    .cnt (match_count)
  );

  assign out = out_q;

endmodule

// File: tb/tb_pattern_detector_moore.sv
// tb/tb_pattern_detector_moore.sv - scoreboard bench for pattern_detector_moore
module tb_pattern_detector_moore;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 16;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset = 1'b1;
  logic               en = 1'b0, in_bit = 1'b0, pat_load = 1'b0, pat_overlap = 1'b0, clr_count = 1'b0;
  logic [MAX_LEN-1:0] pat_value = '0;
  logic [LEN_W-1:0]   pat_len = '0;
  logic               out_bit;
  logic [CNT_W-1:0]   match_count;

  logic               s_en = 1'b0, s_in = 1'b0, s_load = 1'b0, s_povl = 1'b0, s_clr = 1'b0;
  logic [MAX_LEN-1:0] s_pval = '0;
  logic [LEN_W-1:0]   s_plen = '0;
  logic               s_out;
  logic [1:0]         s_cnt;

  pattern_detector_moore dut (
    .clk(clk), .reset(reset), .en(en), .in(in_bit), .pat_load(pat_load),
    .pat_value(pat_value), .pat_len(pat_len), .pat_overlap(pat_overlap),
    .clr_count(clr_count), .out(out_bit), .match_count(match_count)
  );

  pattern_detector_moore #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .en(s_en), .in(s_in), .pat_load(s_load),
    .pat_value(s_pval), .pat_len(s_plen), .pat_overlap(s_povl),
    .clr_count(s_clr), .out(s_out), .match_count(s_cnt)
  );

  typedef struct {bit o; int c;} exp_t;
  exp_t exp_q[$];
  int   cnt_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  logic [MAX_LEN-1:0] m_pat;
  int                 m_len;
  bit                 m_ovl;
  bit                 m_seen[$];
  bit                 m_out;
  int                 m_cnt;

  function automatic void model_reset();
    m_pat = 8'b0000_1011; m_len = 4; m_ovl = 1'b1;
    m_seen.delete(); m_out = 1'b0; m_cnt = 0;
    exp_q.delete();
  endfunction

  function automatic bit model_match();
    if (m_seen.size() < m_len) return 1'b0;
    for (int k = 0; k < m_len; k++)
      if (m_seen[m_seen.size() - 1 - k] != m_pat[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic step(input bit e, input bit b, input bit ld, input logic [MAX_LEN-1:0] pv,
                      input int pl, input bit po, input bit clr);
    en = e; in_bit = b; pat_load = ld; pat_value = pv; pat_len = LEN_W'(pl);
    pat_overlap = po; clr_count = clr;
    if (ld) begin
      m_pat = pv; m_len = (pl < 1) ? 1 : ((pl > MAX_LEN) ? MAX_LEN : pl);
      m_ovl = po; m_seen.delete(); m_out = 1'b0; m_cnt = 0;
    end else begin
      if (clr) m_cnt = 0;
      if (e) begin
        if (!m_ovl && m_out) m_seen.delete();
        m_seen.push_back(b);
        if (m_seen.size() > MAX_LEN) void'(m_seen.pop_front());
        m_out = model_match();
        if (m_out && m_cnt < CNT_MAX) m_cnt++;
      end
    end
    exp_q.push_back('{m_out, m_cnt});
    @(posedge clk); #1;
    en = 1'b0; pat_load = 1'b0; clr_count = 1'b0;
  endtask

  task automatic test_reset();
    exp_t ex;
    reset = 1'b1; #2;
    model_reset();
    n_checks++; if (out_bit !== 1'b0) begin n_fail++; $display("FAIL reset_out: got %0b expected 0", out_bit); end
    n_checks++; if (match_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", match_count); end
    @(posedge clk); #1; reset = 1'b0;
    step(1'b0, 1'b0, 1'b0, '0, 0, 1'b0, 1'b0);
    ex = exp_q.pop_front();
    n_checks++; if (out_bit !== ex.o) begin n_fail++; $display("FAIL reset_idle_out: got %0b expected %0b", out_bit, ex.o); end
  endtask

  task automatic test_defaults();
    int bits[4] = '{1, 0, 1, 1};
    exp_t ex;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, bits[i][0], 1'b0, '0, 0, 1'b0, 1'b0);
      ex = exp_q.pop_front();
      n_checks++; if (out_bit !== ex.o) begin n_fail++; $display("FAIL defaults_out[%0d]: got %0b expected %0b", i, out_bit, ex.o); end
      n_checks++; if (match_count !== CNT_W'(ex.c)) begin n_fail++; $display("FAIL defaults_count[%0d]: got %0d expected %0d", i, match_count, ex.c); end
    end
    n_checks++; if (match_count !== 16'd1) begin n_fail++; $display("FAIL defaults_total: got %0d expected 1", match_count); end
  endtask

  task automatic test_overlap_modes();
    int bits[7] = '{1, 0, 1, 1, 0, 1, 1};
    int want[2] = '{2, 1};
    exp_t ex;
    for (int m = 0; m < 2; m++) begin
      step(1'b0, 1'b1, 1'b1, 8'b0000_1011, 4, (m == 0), 1'b0);
      ex = exp_q.pop_front();
      n_checks++; if (out_bit !== ex.o || match_count !== CNT_W'(ex.c)) begin
        n_fail++; $display("FAIL mode%0d_load: got out=%0b cnt=%0d expected out=%0b cnt=%0d", m, out_bit, match_count, ex.o, ex.c);
      end
      for (int i = 0; i < 7; i++) begin
        step(1'b1, bits[i][0], 1'b0, '0, 0, 1'b0, 1'b0);
        ex = exp_q.pop_front();
        n_checks++; if (out_bit !== ex.o) begin n_fail++; $display("FAIL mode%0d_out[%0d]: got %0b expected %0b", m, i, out_bit, ex.o); end
        n_checks++; if (match_count !== CNT_W'(ex.c)) begin n_fail++; $display("FAIL mode%0d_count[%0d]: got %0d expected %0d", m, i, match_count, ex.c); end
      end
      n_checks++; if (match_count !== CNT_W'(want[m])) begin n_fail++; $display("FAIL mode%0d_total: got %0d expected %0d", m, match_count, want[m]); end
    end
  endtask

  task automatic test_en_gaps();
    int ens[9]  = '{1, 1, 0, 0, 0, 1, 1, 0, 0};
    int bits[9] = '{1, 0, 1, 1, 1, 1, 1, 0, 0};
    exp_t ex;
    step(1'b0, 1'b1, 1'b1, 8'b0000_1011, 4, 1'b1, 1'b0);
    ex = exp_q.pop_front();
    for (int i = 0; i < 9; i++) begin
      step(ens[i][0], bits[i][0], 1'b0, '0, 0, 1'b0, 1'b0);
      ex = exp_q.pop_front();
      n_checks++; if (out_bit !== ex.o) begin n_fail++; $display("FAIL en_gap_out[%0d]: got %0b expected %0b", i, out_bit, ex.o); end
      n_checks++; if (match_count !== CNT_W'(ex.c)) begin n_fail++; $display("FAIL en_gap_count[%0d]: got %0d expected %0d", i, match_count, ex.c); end
    end
    n_checks++; if (out_bit !== 1'b1 || match_count !== 16'd1) begin
      n_fail++; $display("FAIL en_gap_hold: got out=%0b cnt=%0d expected out=1 cnt=1", out_bit, match_count);
    end
  endtask

  task automatic test_runtime_load();
    int lens[3]  = '{3, 0, 12};
    int nbits[3] = '{5, 3, 9};
    logic [MAX_LEN-1:0] pats[3] = '{8'b0000_0111, 8'b0000_0001, 8'b1111_1111};
    exp_t ex;
    for (int p = 0; p < 3; p++) begin
      step(1'b0, 1'b1, 1'b1, pats[p], lens[p], 1'b1, 1'b0);
      ex = exp_q.pop_front();
      for (int i = 0; i < nbits[p]; i++) begin
        step(1'b1, !(p == 1 && i == 1), 1'b0, '0, 0, 1'b0, 1'b0);
        ex = exp_q.pop_front();
        n_checks++; if (out_bit !== ex.o) begin n_fail++; $display("FAIL load%0d_out[%0d]: got %0b expected %0b", p, i, out_bit, ex.o); end
        n_checks++; if (match_count !== CNT_W'(ex.c)) begin n_fail++; $display("FAIL load%0d_count[%0d]: got %0d expected %0d", p, i, match_count, ex.c); end
      end
    end
    n_checks++; if (match_count !== 16'd2) begin n_fail++; $display("FAIL load_clamp_max_total: got %0d expected 2", match_count); end
  endtask

  task automatic test_clr_count();
    exp_t ex;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0, '0, 0, 1'b0, (i == 3));
      ex = exp_q.pop_front();
      n_checks++; if (match_count !== CNT_W'(ex.c)) begin n_fail++; $display("FAIL clr_match_count[%0d]: got %0d expected %0d", i, match_count, ex.c); end
    end
    n_checks++; if (match_count !== 16'd1) begin n_fail++; $display("FAIL clr_with_match: got %0d expected 1", match_count); end
    step(1'b0, 1'b0, 1'b0, '0, 0, 1'b0, 1'b1);
    ex = exp_q.pop_front();
    n_checks++; if (match_count !== CNT_W'(ex.c)) begin n_fail++; $display("FAIL clr_alone: got %0d expected %0d", match_count, ex.c); end
  endtask

  task automatic test_saturation();
    int c;
    s_load = 1'b1; s_pval = 8'b0000_0001; s_plen = LEN_W'(1); s_povl = 1'b1;
    @(posedge clk); #1; s_load = 1'b0;
    for (int i = 0; i < 7; i++) begin
      s_en = (i != 6); s_in = 1'b1; s_clr = (i >= 5);
      cnt_q.push_back((i == 6) ? 0 : (i == 5) ? 1 : (i < 3) ? i + 1 : 3);
      @(posedge clk); #1;
      c = cnt_q.pop_front();
      n_checks++; if (s_cnt !== 2'(c)) begin n_fail++; $display("FAIL sat_count[%0d]: got %0d expected %0d", i, s_cnt, c); end
      n_checks++; if (s_out !== 1'b1) begin n_fail++; $display("FAIL sat_out[%0d]: got %0b expected 1", i, s_out); end
    end
    s_en = 1'b0; s_clr = 1'b0;
  endtask

  task automatic test_async_reset();
    int bits[4] = '{1, 0, 1, 1};
    exp_t ex;
    step(1'b0, 1'b1, 1'b1, 8'b0000_0111, 3, 1'b1, 1'b0);
    ex = exp_q.pop_front();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, '0, 0, 1'b0, 1'b0);
      ex = exp_q.pop_front();
    end
    n_checks++; if (out_bit !== ex.o || match_count !== CNT_W'(ex.c)) begin
      n_fail++; $display("FAIL pre_reset: got out=%0b cnt=%0d expected out=%0b cnt=%0d", out_bit, match_count, ex.o, ex.c);
    end
    #2 reset = 1'b1;
    #1;
    model_reset();
    n_checks++; if (out_bit !== 1'b0) begin n_fail++; $display("FAIL async_reset_out: got %0b expected 0", out_bit); end
    n_checks++; if (match_count !== '0) begin n_fail++; $display("FAIL async_reset_count: got %0d expected 0", match_count); end
    #2 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, bits[i][0], 1'b0, '0, 0, 1'b0, 1'b0);
      ex = exp_q.pop_front();
      n_checks++; if (out_bit !== ex.o) begin n_fail++; $display("FAIL post_reset_out[%0d]: got %0b expected %0b", i, out_bit, ex.o); end
    end
    n_checks++; if (out_bit !== 1'b1 || match_count !== 16'd1) begin
      n_fail++; $display("FAIL post_reset_default: got out=%0b cnt=%0d expected out=1 cnt=1", out_bit, match_count);
    end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_overlap_modes();
    test_en_gaps();
    test_runtime_load();
    test_clr_count();
    test_saturation();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
